// File: rtl/axi_expand_complex_if.sv
// AXI-Stream style channel used on both sides of the complex expander.
// A beat transfers on a rising edge where tvalid and tready are both high; tdata/tlast must hold while tvalid=1 and tready=0.
interface axi_expand_complex_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi_expand_complex.sv
// Complex sample widener: per-packet left shift, then saturation to WIDTH_OUT bits per component.
// Two-stage valid/ready pipeline; sat_count tallies output beats that clipped.
module axi_expand_complex #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           shift,
  input  logic                 clear,
  axi_expand_complex_if.slave  i,
  axi_expand_complex_if.master o,
  output logic [15:0]          sat_count
);
  localparam int WE = WIDTH_IN + WIDTH_OUT;
  localparam logic [5:0] S_MAX = 6'(WIDTH_OUT);
  localparam logic signed [WE-1:0] MAX_V = {{(WIDTH_IN+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WE-1:0] MIN_V = {{(WIDTH_IN+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

  logic                      sop;
  logic [4:0]                pkt_shift;
  logic [4:0]                shift_sel;
  logic [5:0]                s_eff;
  logic                      s1_valid, s1_last;
  logic signed [WE-1:0]      s1_i, s1_q;
  logic                      s2_valid, s2_last, s2_sat;
  logic [2*WIDTH_OUT-1:0]    s2_data;
  logic                      s1_adv, s2_adv, in_fire, out_fire;
  logic signed [WE-1:0]      ext_i, ext_q;
  logic [WIDTH_OUT-1:0]      sat_i_val, sat_q_val;
  logic                      sat_i, sat_q;

  function automatic logic [WIDTH_OUT:0] saturate(input logic signed [WE-1:0] v);
    if (v > MAX_V)      return {1'b1, MAX_V[WIDTH_OUT-1:0]};
    else if (v < MIN_V) return {1'b1, MIN_V[WIDTH_OUT-1:0]};
    else                return {1'b0, v[WIDTH_OUT-1:0]};
  endfunction

  always_comb begin
    s2_adv   = ~s2_valid | o.tready;
    s1_adv   = ~s1_valid | s2_adv;
    in_fire  = i.tvalid & s1_adv & ~reset;
    out_fire = s2_valid & o.tready;
    // The SOP beat uses the shift value presented with it, not the stale packet value.
    shift_sel = sop ? shift : pkt_shift;
    s_eff     = ({1'b0, shift_sel} > S_MAX) ? S_MAX : {1'b0, shift_sel};
    ext_i = {{WIDTH_OUT{i.tdata[2*WIDTH_IN-1]}}, i.tdata[2*WIDTH_IN-1:WIDTH_IN]};
    ext_q = {{WIDTH_OUT{i.tdata[WIDTH_IN-1]}},   i.tdata[WIDTH_IN-1:0]};
    {sat_i, sat_i_val} = saturate(s1_i);
    {sat_q, sat_q_val} = saturate(s1_q);
  end

  assign i.tready = s1_adv & ~reset;
  assign o.tvalid = s2_valid;
  assign o.tlast  = s2_last;
  assign o.tdata  = s2_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sop       <= 1'b1;
      pkt_shift <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_sat    <= 1'b0;
      s2_data   <= '0;
    end else begin
      if (in_fire) begin
        sop <= i.tlast;
        if (sop) pkt_shift <= shift;
      end
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_i    <= ext_i <<< s_eff;
          s1_q    <= ext_q <<< s_eff;
          s1_last <= i.tlast;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= {sat_i_val, sat_q_val};
          s2_last <= s1_last;
          s2_sat  <= sat_i | sat_q;
        end
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (clear) begin
      sat_count <= '0;
    end else if (out_fire && s2_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_axi_expand_complex.sv
// Bench for axi_expand_complex: directed scenarios plus randomized streaming against a
// arithmetic reference model and an expected-beat queue.
module tb_axi_expand_complex;
  logic        clk;
  logic        reset;
  logic [4:0]  shift;
  logic        clear;
  logic [15:0] sat_count;

  axi_expand_complex_if #(.W(32)) in_if ();
  axi_expand_complex_if #(.W(48)) out_if ();

  axi_expand_complex #(.WIDTH_IN(16), .WIDTH_OUT(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .shift     (shift),
    .clear     (clear),
    .i         (in_if),
    .o         (out_if),
    .sat_count (sat_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  int n_pass  = 0;
  int n_total = 0;

  // scoreboard state: {sat, last, I, Q}
  logic [49:0] exp_q[$];
  logic [48:0] got_q[$];
  bit          m_sop    = 1'b1;
  int          m_shift  = 0;
  int          exp_cnt  = 0;
  bit          prev_stall = 1'b0;
  logic [48:0] prev_out;

  function automatic logic [24:0] ref_comp(input logic [15:0] x, input int s);
    longint v;
    v = longint'($signed(x)) << s;
    if (v > 64'sd8388607)       return {1'b1, 24'h7FFFFF};
    else if (v < -64'sd8388608) return {1'b1, 24'h800000};
    else                        return {1'b0, v[23:0]};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_sop      = 1'b1;
      exp_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      logic [24:0] ri, rq;
      logic [49:0] e;
      int s;
      n_total++;
      if (sat_count !== 16'(exp_cnt))
        $display("FAIL sat_count: got %h expected %h at %0t", sat_count, 16'(exp_cnt), $time);
      else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (out_if.tvalid !== 1'b1 || {out_if.tlast, out_if.tdata} !== prev_out)
          $display("FAIL hold_stable: got v=%b %h expected v=1 %h", out_if.tvalid,
                   {out_if.tlast, out_if.tdata}, prev_out);
        else n_pass++;
      end
      if (in_if.tvalid && in_if.tready) begin
        if (m_sop) m_shift = int'(shift);
        s  = (m_shift > 24) ? 24 : m_shift;
        ri = ref_comp(in_if.tdata[31:16], s);
        rq = ref_comp(in_if.tdata[15:0], s);
        exp_q.push_back({ri[24] | rq[24], in_if.tlast, ri[23:0], rq[23:0]});
        m_sop = in_if.tlast;
      end
      if (out_if.tvalid && out_if.tready) begin
        got_q.push_back({out_if.tlast, out_if.tdata});
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_beat: got %h expected no beat", {out_if.tlast, out_if.tdata});
        end else begin
          e = exp_q.pop_front();
          if ({out_if.tlast, out_if.tdata} !== e[48:0])
            $display("FAIL out_beat: got %h expected %h", {out_if.tlast, out_if.tdata}, e[48:0]);
          else n_pass++;
          if (!clear && e[49] && exp_cnt < 65535) exp_cnt++;
        end
      end
      if (clear) exp_cnt = 0;
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_out   = {out_if.tlast, out_if.tdata};
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [4:0] sh);
    bit ok = 1'b0;
    in_if.tdata  = d;
    in_if.tlast  = last;
    shift        = sh;
    in_if.tvalid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_if.tready;
      @(posedge clk);
      #1;
    end
    in_if.tvalid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: got no handshake, expected handshake within 50 cycles");
    end
  endtask

  // ready_mode: 0 = o_tready low, 1 = high, 2 = random
  task automatic stream(input int cycles, input int ready_mode, output int acc);
    bit took = 1'b1;
    acc = 0;
    for (int c = 0; c < cycles; c++) begin
      if (took) begin
        in_if.tdata = $urandom;
        in_if.tlast = ($urandom_range(0, 3) == 0);
        shift       = 5'($urandom_range(0, 31));
      end
      in_if.tvalid = 1'b1;
      if (ready_mode == 0)      out_if.tready = 1'b0;
      else if (ready_mode == 1) out_if.tready = 1'b1;
      else                      out_if.tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = in_if.tready;
      if (took) acc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_total++; if (out_if.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", out_if.tvalid); else n_pass++;
    n_total++; if (out_if.tdata !== 48'h0) $display("FAIL rst_tdata: got %h expected 0", out_if.tdata); else n_pass++;
    n_total++; if (out_if.tlast !== 1'b0) $display("FAIL rst_tlast: got %b expected 0", out_if.tlast); else n_pass++;
    n_total++; if (sat_count !== 16'h0) $display("FAIL rst_sat_count: got %h expected 0", sat_count); else n_pass++;
    n_total++; if (in_if.tready !== 1'b0) $display("FAIL rst_tready: got %b expected 0", in_if.tready); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (in_if.tready !== 1'b1) $display("FAIL post_rst_tready: got %b expected 1", in_if.tready); else n_pass++;
  endtask

  task automatic test_basic();
    out_if.tready = 1'b1;
    send_beat({16'h1234, 16'hFFFF}, 1'b1, 5'd4);
    n_total++; if (out_if.tvalid !== 1'b0) $display("FAIL latency_early: got %b expected 0", out_if.tvalid); else n_pass++;
    tick();
    n_total++; if (out_if.tvalid !== 1'b1) $display("FAIL latency_n2: got %b expected 1", out_if.tvalid); else n_pass++;
    n_total++; if (out_if.tdata !== 48'h012340FFFFF0) $display("FAIL basic_data: got %h expected 012340fffff0", out_if.tdata); else n_pass++;
    n_total++; if (out_if.tlast !== 1'b1) $display("FAIL basic_last: got %b expected 1", out_if.tlast); else n_pass++;
    tick(); tick();
    n_total++; if (sat_count !== 16'h0) $display("FAIL basic_sat_count: got %h expected 0", sat_count); else n_pass++;
  endtask

  task automatic test_saturation();
    out_if.tready = 1'b1;
    send_beat({16'h7FFF, 16'h8000}, 1'b1, 5'd9);
    tick();
    n_total++; if (out_if.tdata !== 48'h7FFFFF800000) $display("FAIL sat9_data: got %h expected 7fffff800000", out_if.tdata); else n_pass++;
    tick();
    n_total++; if (sat_count !== 16'd1) $display("FAIL sat9_count: got %h expected 1", sat_count); else n_pass++;
    send_beat({16'h7FFF, 16'h8000}, 1'b1, 5'd8);
    tick();
    n_total++; if (out_if.tdata !== 48'h7FFF00800000) $display("FAIL sat8_data: got %h expected 7fff00800000", out_if.tdata); else n_pass++;
    tick();
    n_total++; if (sat_count !== 16'd1) $display("FAIL sat8_count: got %h expected 1", sat_count); else n_pass++;
    send_beat(32'h0, 1'b1, 5'd24);
    tick();
    n_total++; if (out_if.tdata !== 48'h0) $display("FAIL zero_data: got %h expected 0", out_if.tdata); else n_pass++;
    send_beat({16'h8001, 16'h0001}, 1'b1, 5'd0);
    tick();
    n_total++; if (out_if.tdata !== 48'hFF8001000001) $display("FAIL s0_data: got %h expected ff8001000001", out_if.tdata); else n_pass++;
    send_beat({16'h0001, 16'hFFFF}, 1'b1, 5'd31);
    tick();
    n_total++; if (out_if.tdata !== 48'h7FFFFF800000) $display("FAIL s31_data: got %h expected 7fffff800000", out_if.tdata); else n_pass++;
    tick();
    n_total++; if (sat_count !== 16'd2) $display("FAIL s31_count: got %h expected 2", sat_count); else n_pass++;
  endtask

  task automatic test_shift_hold();
    logic [31:0] d = {16'h0001, 16'hFFFF};
    logic [48:0] e;
    out_if.tready = 1'b1;
    got_q.delete();
    send_beat(d, 1'b0, 5'd2);
    send_beat(d, 1'b0, 5'd2);
    send_beat(d, 1'b0, 5'd6);
    send_beat(d, 1'b1, 5'd6);
    send_beat(d, 1'b1, 5'd6);
    repeat (4) tick();
    n_total++;
    if (got_q.size() != 5) $display("FAIL hold_count: got %0d expected 5", got_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        e = {1'(k == 3), 24'h000004, 24'hFFFFFC};
        n_total++;
        if (got_q[k] !== e) $display("FAIL hold_beat%0d: got %h expected %h", k, got_q[k], e);
        else n_pass++;
      end
      n_total++;
      if (got_q[4] !== {1'b1, 24'h000040, 24'hFFFFC0})
        $display("FAIL hold_next_pkt: got %h expected 1000040ffffc0", got_q[4]);
      else n_pass++;
    end
  endtask

  task automatic test_stall_random();
    int acc;
    in_if.tvalid = 1'b0;
    out_if.tready = 1'b1;
    repeat (4) tick();
    stream(5, 0, acc);
    n_total++; if (acc != 2) $display("FAIL stall_absorb: got %0d expected 2", acc); else n_pass++;
    n_total++; if (in_if.tready !== 1'b0) $display("FAIL stall_tready: got %b expected 0", in_if.tready); else n_pass++;
    stream(300, 2, acc);
    stream(40, 1, acc);
    n_total++; if (acc != 40) $display("FAIL throughput: got %0d expected 40", acc); else n_pass++;
    in_if.tvalid = 1'b0;
    repeat (5) tick();
    n_total++; if (exp_q.size() != 0) $display("FAIL drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_sat_count();
    int acc = 0;
    out_if.tready = 1'b1;
    in_if.tdata  = {16'h7FFF, 16'h7FFF};
    in_if.tlast  = 1'b1;
    shift        = 5'd24;
    in_if.tvalid = 1'b1;
    for (int c = 0; c < 70000 && acc < 65540; c++) begin
      @(negedge clk);
      if (in_if.tready) acc++;
      @(posedge clk);
      #1;
    end
    in_if.tvalid = 1'b0;
    repeat (4) tick();
    n_total++; if (acc != 65540) $display("FAIL sat_beats: got %0d expected 65540", acc); else n_pass++;
    n_total++; if (sat_count !== 16'hFFFF) $display("FAIL sat_sticky: got %h expected ffff", sat_count); else n_pass++;
    out_if.tready = 1'b0;
    send_beat({16'h7FFF, 16'h7FFF}, 1'b1, 5'd24);
    tick();
    n_total++; if (out_if.tvalid !== 1'b1) $display("FAIL clr_setup: got %b expected 1", out_if.tvalid); else n_pass++;
    out_if.tready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_total++; if (sat_count !== 16'h0) $display("FAIL clear_priority: got %h expected 0", sat_count); else n_pass++;
    send_beat({16'h7FFF, 16'h7FFF}, 1'b1, 5'd24);
    repeat (2) tick();
    n_total++; if (sat_count !== 16'd1) $display("FAIL after_clear: got %h expected 1", sat_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_if.tready = 1'b1;
    send_beat({16'h0100, 16'h0200}, 1'b0, 5'd3);
    send_beat({16'h0300, 16'h0400}, 1'b0, 5'd3);
    #1;
    reset = 1'b1;
    #1;
    n_total++; if (out_if.tvalid !== 1'b0) $display("FAIL rst_mid_tvalid: got %b expected 0", out_if.tvalid); else n_pass++;
    n_total++; if (in_if.tready !== 1'b0) $display("FAIL rst_mid_tready: got %b expected 0", in_if.tready); else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    got_q.delete();
    send_beat({16'h0003, 16'hFFFD}, 1'b1, 5'd5);
    repeat (3) tick();
    n_total++;
    if (got_q.size() != 1) $display("FAIL rst_mid_count: got %0d expected 1", got_q.size());
    else begin
      n_pass++;
      n_total++;
      if (got_q[0] !== {1'b1, 24'h000060, 24'hFFFFA0})
        $display("FAIL rst_mid_sop: got %h expected 1000060ffffa0", got_q[0]);
      else n_pass++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    shift         = '0;
    in_if.tdata   = '0;
    in_if.tlast   = 1'b0;
    in_if.tvalid  = 1'b0;
    out_if.tready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_shift_hold();
    test_stall_random();
    test_sat_count();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
